// File: rtl/branch_predictor_if.sv
// Fetch/resolve/flush bundle between the front end and the branch predictor.
// The master drives lookups and resolutions; the slave returns predictions.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_pc;
  logic            pred_valid;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            res_valid;
  logic [XLEN-1:0] res_pc;
  logic            res_is_jump;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic            flush;

  modport master (
    output fetch_valid, fetch_pc,
    output res_valid, res_pc, res_is_jump, res_taken, res_target,
    output flush,
    input  pred_valid, pred_hit, pred_taken, pred_target
  );

  modport slave (
    input  fetch_valid, fetch_pc,
    input  res_valid, res_pc, res_is_jump, res_taken, res_target,
    input  flush,
    output pred_valid, pred_hit, pred_taken, pred_target
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, flop storage.
// One lookup and one resolution per cycle; prediction is registered.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  branch_predictor_if.slave  bp_if
);

  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int TAG_LSB = IDX_W + 2;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [XLEN-1:0]  addr_t;
  typedef logic [1:0]       ctr_t;

  function automatic ctr_t ctr_step(input ctr_t ctr, input logic up);
    ctr_t res;
    if (up) begin
      res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return res;
  endfunction

  logic [ENTRIES-1:0] valid_q, valid_d;
  tag_t               tag_q    [ENTRIES];
  tag_t               tag_d    [ENTRIES];
  addr_t              target_q [ENTRIES];
  addr_t              target_d [ENTRIES];
  ctr_t               ctr_q    [ENTRIES];
  ctr_t               ctr_d    [ENTRIES];

  logic  pred_valid_q, pred_valid_d;
  logic  pred_hit_q, pred_hit_d;
  logic  pred_taken_q, pred_taken_d;
  addr_t pred_target_q, pred_target_d;

  idx_t f_idx_s, r_idx_s;
  tag_t f_tag_s, r_tag_s;
  logic f_hit_s, r_hit_s, r_take_s;
  logic unused_s;

  assign f_idx_s  = bp_if.fetch_pc[TAG_LSB-1:2];
  assign f_tag_s  = bp_if.fetch_pc[TAG_LSB+TAG_W-1:TAG_LSB];
  assign r_idx_s  = bp_if.res_pc[TAG_LSB-1:2];
  assign r_tag_s  = bp_if.res_pc[TAG_LSB+TAG_W-1:TAG_LSB];
  assign f_hit_s  = valid_q[f_idx_s] && (tag_q[f_idx_s] == f_tag_s);
  assign r_hit_s  = valid_q[r_idx_s] && (tag_q[r_idx_s] == r_tag_s);
  assign r_take_s = bp_if.res_taken | bp_if.res_is_jump;
  assign unused_s = ^{bp_if.fetch_pc, bp_if.res_pc};

  // Lookup reads pre-update table contents; outputs hold when no fetch.
  always_comb begin
    pred_valid_d  = 1'b0;
    pred_hit_d    = pred_hit_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (bp_if.fetch_valid) begin
      pred_valid_d  = 1'b1;
      pred_hit_d    = f_hit_s;
      pred_taken_d  = f_hit_s && ctr_q[f_idx_s][1];
      pred_target_d = (f_hit_s && ctr_q[f_idx_s][1]) ? target_q[f_idx_s]
                                                       : bp_if.fetch_pc + XLEN'(32'd4);
    end else begin
      pred_valid_d  = 1'b0;
    end
  end

  // Table training; flush clears valids only and drops any same-cycle update.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (bp_if.flush) begin
      valid_d = {ENTRIES{1'b0}};
    end else if (bp_if.res_valid) begin
      if (r_hit_s) begin
        ctr_d[r_idx_s] = bp_if.res_is_jump ? 2'b11
                                           : ctr_step(ctr_q[r_idx_s], bp_if.res_taken);
        if (r_take_s) begin
          target_d[r_idx_s] = bp_if.res_target;
        end else begin
          target_d[r_idx_s] = target_q[r_idx_s];
        end
      end else if (r_take_s) begin
        valid_d[r_idx_s]  = 1'b1;
        tag_d[r_idx_s]    = r_tag_s;
        target_d[r_idx_s] = bp_if.res_target;
        ctr_d[r_idx_s]    = bp_if.res_is_jump ? 2'b11 : 2'b10;
      end else begin
        valid_d = valid_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Table state; counters come out of reset weakly not-taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= {TAG_W{1'b0}};
        target_q[i] <= {XLEN{1'b0}};
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

  // Prediction output register; reset discards any in-flight lookup.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= {XLEN{1'b0}};
    end else begin
      pred_valid_q  <= pred_valid_d;
      pred_hit_q    <= pred_hit_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  assign bp_if.pred_valid  = pred_valid_q;
  assign bp_if.pred_hit    = pred_hit_q;
  assign bp_if.pred_taken  = pred_taken_q;
  assign bp_if.pred_target = pred_target_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios with literal expectations,
// then random traffic checked against an arithmetic table model.
module tb_branch_predictor;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int TAG_W   = 8;
  localparam int IDX_W   = $clog2(ENTRIES);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passed = 0;

  branch_predictor_if #(.XLEN(XLEN)) bp();

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bp_if (bp)
  );

  always #5 clk = ~clk;

  // reference model state
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic        exp_v, exp_h, exp_t;
  logic [31:0] exp_tgt;
  logic [34:0] got, want;

  // drive one cycle of stimulus, advance the model, sample 1 time unit after the edge
  task automatic cycle(input logic fv, input logic [31:0] fpc, input logic rv,
                       input logic [31:0] rpc, input logic rj, input logic rt,
                       input logic [31:0] rtgt, input logic fl, input logic r);
    int unsigned idx, tg;
    bit h, t;
    bp.fetch_valid = fv;  bp.fetch_pc = fpc;
    bp.res_valid = rv;    bp.res_pc = rpc;  bp.res_is_jump = rj;
    bp.res_taken = rt;    bp.res_target = rtgt;
    bp.flush = fl;        rst = r;
    if (r) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i] = 1;
      end
      exp_v = 1'b0; exp_h = 1'b0; exp_t = 1'b0; exp_tgt = 32'h0;
    end else begin
      if (fv) begin
        idx = (fpc >> 2) % ENTRIES;
        tg  = (fpc >> (2 + IDX_W)) % (1 << TAG_W);
        exp_v   = 1'b1;
        exp_h   = m_valid[idx] && (m_tag[idx] == tg);
        exp_t   = exp_h && (m_ctr[idx] >= 2);
        exp_tgt = exp_t ? m_target[idx] : fpc + 32'd4;
      end else begin
        exp_v = 1'b0;
      end
      if (fl) begin
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      end else if (rv) begin
        idx = (rpc >> 2) % ENTRIES;
        tg  = (rpc >> (2 + IDX_W)) % (1 << TAG_W);
        t   = rt || rj;
        h   = m_valid[idx] && (m_tag[idx] == tg);
        if (h) begin
          if (rj) m_ctr[idx] = 3;
          else if (rt) m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
          else m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
          if (t) m_target[idx] = rtgt;
        end else if (t) begin
          m_valid[idx] = 1'b1;
          m_tag[idx] = tg;
          m_target[idx] = rtgt;
          m_ctr[idx] = rj ? 3 : 2;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    cycle(1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic j, input logic tk, input logic [31:0] tgt);
    cycle(1'b0, 32'h0, 1'b1, pc, j, tk, tgt, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    got = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
    checks++;
    if (got !== 35'h0) $display("FAIL reset_outputs got=%h exp=%h", got, 35'h0);
    else passed++;
    lookup(32'h100);
    got = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
    want = {1'b1, 1'b0, 1'b0, 32'h104};
    checks++;
    if (got !== want) $display("FAIL cold_lookup got=%h exp=%h", got, want);
    else passed++;
    lookup(32'hFFFF_FFFC);
    got = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
    want = {1'b1, 1'b0, 1'b0, 32'h0};
    checks++;
    if (got !== want) $display("FAIL pc_wrap got=%h exp=%h", got, want);
    else passed++;
  endtask

  task automatic test_train();
    logic [34:0] exp_seq [4];
    exp_seq[0] = {1'b1, 1'b1, 1'b1, 32'h80};
    exp_seq[1] = {1'b1, 1'b1, 1'b0, 32'h104};
    exp_seq[2] = {1'b0, 1'b1, 1'b0, 32'h104};
    resolve(32'h100, 1'b0, 1'b1, 32'h80);
    lookup(32'h100);
    got = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
    checks++;
    if (got !== exp_seq[0]) $display("FAIL train_taken got=%h exp=%h", got, exp_seq[0]);
    else passed++;
    resolve(32'h100, 1'b0, 1'b0, 32'h0);
    resolve(32'h100, 1'b0, 1'b0, 32'h0);
    lookup(32'h100);
    got = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
    checks++;
    if (got !== exp_seq[1]) $display("FAIL train_not_taken got=%h exp=%h", got, exp_seq[1]);
    else passed++;
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    got = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
    checks++;
    if (got !== exp_seq[2]) $display("FAIL idle_hold got=%h exp=%h", got, exp_seq[2]);
    else passed++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) resolve(32'h200, 1'b0, 1'b1, 32'h240);
    resolve(32'h200, 1'b0, 1'b0, 32'h0);
    lookup(32'h200);
    got = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
    want = {1'b1, 1'b1, 1'b1, 32'h240};
    checks++;
    if (got !== want) $display("FAIL sat_high got=%h exp=%h", got, want);
    else passed++;
    resolve(32'h200, 1'b0, 1'b0, 32'h0);
    lookup(32'h200);
    got = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
    want = {1'b1, 1'b1, 1'b0, 32'h204};
    checks++;
    if (got !== want) $display("FAIL sat_drop got=%h exp=%h", got, want);
    else passed++;
    resolve(32'h300, 1'b1, 1'b0, 32'h500);
    resolve(32'h300, 1'b0, 1'b0, 32'h0);
    lookup(32'h300);
    got = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
    want = {1'b1, 1'b1, 1'b1, 32'h500};
    checks++;
    if (got !== want) $display("FAIL jal_strong got=%h exp=%h", got, want);
    else passed++;
  endtask

  task automatic test_alias();
    resolve(32'h100, 1'b0, 1'b1, 32'h180);
    resolve(32'h100 + 32'(4 * ENTRIES), 1'b0, 1'b1, 32'h900);
    lookup(32'h100);
    got = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
    want = {1'b1, 1'b0, 1'b0, 32'h104};
    checks++;
    if (got !== want) $display("FAIL alias_evicted got=%h exp=%h", got, want);
    else passed++;
    lookup(32'h100 + 32'(4 * ENTRIES));
    got = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
    want = {1'b1, 1'b1, 1'b1, 32'h900};
    checks++;
    if (got !== want) $display("FAIL alias_hit got=%h exp=%h", got, want);
    else passed++;
  endtask

  task automatic test_flush();
    cycle(1'b1, 32'h400, 1'b1, 32'h400, 1'b0, 1'b1, 32'h480, 1'b0, 1'b0);
    got = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
    want = {1'b1, 1'b0, 1'b0, 32'h404};
    checks++;
    if (got !== want) $display("FAIL no_bypass got=%h exp=%h", got, want);
    else passed++;
    resolve(32'h124, 1'b0, 1'b1, 32'h1000);
    lookup(32'h124);
    got = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
    want = {1'b1, 1'b1, 1'b1, 32'h1000};
    checks++;
    if (got !== want) $display("FAIL pre_flush_hit got=%h exp=%h", got, want);
    else passed++;
    cycle(1'b1, 32'h400, 1'b1, 32'h400, 1'b0, 1'b1, 32'h490, 1'b1, 1'b0);
    got = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
    want = {1'b1, 1'b1, 1'b1, 32'h480};
    checks++;
    if (got !== want) $display("FAIL flush_cycle_lookup got=%h exp=%h", got, want);
    else passed++;
    lookup(32'h400);
    got = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
    want = {1'b1, 1'b0, 1'b0, 32'h404};
    checks++;
    if (got !== want) $display("FAIL flush_drops_update got=%h exp=%h", got, want);
    else passed++;
    lookup(32'h124);
    got = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
    want = {1'b1, 1'b0, 1'b0, 32'h128};
    checks++;
    if (got !== want) $display("FAIL flush_invalidates got=%h exp=%h", got, want);
    else passed++;
  endtask

  task automatic test_reset_inflight();
    resolve(32'h800, 1'b0, 1'b1, 32'h880);
    lookup(32'h800);
    got = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
    want = {1'b1, 1'b1, 1'b1, 32'h880};
    checks++;
    if (got !== want) $display("FAIL trained_hit got=%h exp=%h", got, want);
    else passed++;
    cycle(1'b1, 32'h800, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    got = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
    checks++;
    if (got !== 35'h0) $display("FAIL reset_discard got=%h exp=%h", got, 35'h0);
    else passed++;
    lookup(32'h800);
    got = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
    want = {1'b1, 1'b0, 1'b0, 32'h804};
    checks++;
    if (got !== want) $display("FAIL reset_forgets got=%h exp=%h", got, want);
    else passed++;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    if ($urandom_range(0, 15) == 0) pc = $urandom & 32'hFFFF_FFFC;
    else pc = (32'($urandom_range(0, 3)) << (2 + IDX_W)) | (32'($urandom_range(0, 3)) << 2);
    return pc;
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 3) != 0), rand_pc(), 1'($urandom_range(0, 1)), rand_pc(),
            ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0));
      got  = {bp.pred_valid, bp.pred_hit, bp.pred_taken, bp.pred_target};
      want = {exp_v, exp_h, exp_t, exp_tgt};
      checks++;
      if (got !== want) $display("FAIL random_cycle_%0d got=%h exp=%h", n, got, want);
      else passed++;
    end
  endtask

  initial begin
    bp.fetch_valid = 1'b0; bp.fetch_pc = 32'h0;
    bp.res_valid = 1'b0;   bp.res_pc = 32'h0;   bp.res_is_jump = 1'b0;
    bp.res_taken = 1'b0;   bp.res_target = 32'h0; bp.flush = 1'b0;
    test_reset();
    test_train();
    test_saturation();
    test_alias();
    test_flush();
    test_reset_inflight();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
